// File: rtl/mutex_agent_pkg.sv
// Shared types for the mutex lock agent: command ops, response status codes,
// FSM state encoding and Avalon mutex register addresses.
package mutex_agent_pkg;

  typedef enum logic {
    OP_ACQUIRE = 1'b0,
    OP_RELEASE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_TIMEOUT   = 2'b01,
    ST_NOT_OWNER = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ_WR,
    S_ACQ_RD,
    S_BACKOFF,
    S_REL_RD,
    S_REL_WR,
    S_RESP
  } state_e;

  localparam logic ADDR_MUTEX = 1'b0;
  localparam logic ADDR_RESET = 1'b1;

endpackage

// File: rtl/mutex_backoff_timer.sv
// Exponential backoff: holds the current delay (doubling, saturating) and a
// down-counter that flags the last cycle of the wait.
module mutex_backoff_timer #(
  parameter int BACKOFF_W    = 8,
  parameter int BACKOFF_INIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_init,
  input  logic i_load,
  input  logic i_double,
  output logic o_expired
);

  localparam logic [BACKOFF_W-1:0] INIT_VAL = BACKOFF_W'(BACKOFF_INIT);
  localparam logic [BACKOFF_W-1:0] MAX_VAL  = '1;

  logic [BACKOFF_W-1:0] r_backoff;
  logic [BACKOFF_W-1:0] r_count;
  logic [BACKOFF_W-1:0] w_doubled;

  // Doubling overflows exactly when the top bit is set, so that is the saturation point.
  assign w_doubled = r_backoff[BACKOFF_W-1] ? MAX_VAL : {r_backoff[BACKOFF_W-2:0], 1'b0};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_backoff <= INIT_VAL;
      r_count   <= '0;
    end else begin
      if (i_init)
        r_backoff <= INIT_VAL;
      else if (i_double)
        r_backoff <= w_doubled;

      if (i_load)
        r_count <= r_backoff;
      else if (r_count != '0)
        r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == BACKOFF_W'(1));

endmodule

// File: rtl/mutex_lock_agent.sv
// Lock-acquire engine in front of an Avalon-MM hardware mutex: runs the
// write/readback/compare protocol with backoff and reports one status per command.
module mutex_lock_agent
  import mutex_agent_pkg::*;
#(
  parameter logic [15:0] OWNER_ID     = 16'h0001,
  parameter logic [15:0] LOCK_VALUE   = 16'h0001,
  parameter int          MAX_RETRIES  = 255,
  parameter int          BACKOFF_W    = 8,
  parameter int          BACKOFF_INIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic        held,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int          RC_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [31:0] ACQ_WORD = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] REL_WORD = {OWNER_ID, 16'h0000};

  state_e          r_state, w_next;
  status_e         r_status, w_status_next;
  logic            r_held, w_held_next;
  logic [RC_W-1:0] r_retry_cnt;
  logic            w_retry_clr, w_retry_inc;
  logic            w_timer_init, w_timer_load, w_timer_double, w_timer_expired;
  logic            w_acq_match, w_rel_owner, w_retry_exhausted;

  assign w_acq_match       = (avm_readdata == ACQ_WORD);
  assign w_rel_owner       = (avm_readdata[31:16] == OWNER_ID) && (avm_readdata[15:0] != 16'h0000);
  assign w_retry_exhausted = (MAX_RETRIES != 0) && (r_retry_cnt == RC_W'(MAX_RETRIES));

  mutex_backoff_timer #(
    .BACKOFF_W   (BACKOFF_W),
    .BACKOFF_INIT(BACKOFF_INIT)
  ) u_backoff (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_init   (w_timer_init),
    .i_load   (w_timer_load),
    .i_double (w_timer_double),
    .o_expired(w_timer_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_status    <= ST_OK;
      r_held      <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_status <= w_status_next;
      r_held   <= w_held_next;
      if (w_retry_clr)
        r_retry_cnt <= '0;
      else if (w_retry_inc)
        r_retry_cnt <= r_retry_cnt + 1'b1;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next         = r_state;
    w_status_next  = r_status;
    w_held_next    = r_held;
    w_retry_clr    = 1'b0;
    w_retry_inc    = 1'b0;
    w_timer_init   = 1'b0;
    w_timer_load   = 1'b0;
    w_timer_double = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (op_e'(cmd_op) == OP_RELEASE) begin
            w_next = S_REL_RD;
          end else begin
            w_next       = S_ACQ_WR;
            w_retry_clr  = 1'b1;
            w_timer_init = 1'b1;
          end
        end
      end
      S_ACQ_WR: if (!avm_waitrequest) w_next = S_ACQ_RD;
      S_ACQ_RD: begin
        if (!avm_waitrequest) begin
          if (w_acq_match) begin
            w_next        = S_RESP;
            w_status_next = ST_OK;
            w_held_next   = 1'b1;
          end else if (w_retry_exhausted) begin
            // Readback shows another owner, so any earlier hold is gone too.
            w_next        = S_RESP;
            w_status_next = ST_TIMEOUT;
            w_held_next   = 1'b0;
          end else begin
            w_next       = S_BACKOFF;
            w_retry_inc  = 1'b1;
            w_timer_load = 1'b1;
          end
        end
      end
      S_BACKOFF: begin
        if (w_timer_expired) begin
          w_next         = S_ACQ_WR;
          w_timer_double = 1'b1;
        end
      end
      S_REL_RD: begin
        if (!avm_waitrequest) begin
          if (w_rel_owner) begin
            w_next = S_REL_WR;
          end else begin
            w_next        = S_RESP;
            w_status_next = ST_NOT_OWNER;
            w_held_next   = 1'b0;
          end
        end
      end
      S_REL_WR: begin
        if (!avm_waitrequest) begin
          w_next        = S_RESP;
          w_status_next = ST_OK;
          w_held_next   = 1'b0;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus strobes decode straight from the registered state, so they stay stable under waitrequest.
  always_comb begin
    avm_read      = (r_state == S_ACQ_RD) || (r_state == S_REL_RD);
    avm_write     = (r_state == S_ACQ_WR) || (r_state == S_REL_WR);
    avm_writedata = '0;
    if (r_state == S_ACQ_WR)
      avm_writedata = ACQ_WORD;
    else if (r_state == S_REL_WR)
      avm_writedata = REL_WORD;
  end

  assign avm_chipselect = avm_read | avm_write;
  assign avm_address    = ADDR_MUTEX;
  assign cmd_ready      = reset_n && (r_state == S_IDLE);
  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_status     = r_status;
  assign held           = r_held;

endmodule
